pipe_mem_arbiter: RTL
=====================

Name: pipe_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RISC-V pipeline.
- Runs a request/acknowledge handshake on each client side and a valid/ready handshake on the memory side.
- Produces per-stage stall signals for the pipeline registers.
- Fixed priority to MEM, with a starvation guard for IF, and cancellation of in-flight fetches on branch flush.

Parameters:
- ADDR_W, 32, address width for both clients and the memory port
- DATA_W, 32, data width; must be a multiple of 8
- STARVE_MAX, 4, consecutive MEM grants while IF is waiting, after which IF is forced next; range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_flush  in  1  branch/jump redirect; cancels a pending or in-flight fetch
- if_rdata  out  DATA_W  fetched instruction; valid only when if_ack is high
- if_ack  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_ack
- dm_req  in  1  data access request; held until dm_ack
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_wstrb  in  DATA_W/8  byte-enable strobes for stores
- dm_rdata  out  DATA_W  load data; valid only when dm_ack is high
- dm_ack  out  1  one-cycle data completion pulse
- dm_stall  out  1  dm_req & ~dm_ack
- mem_valid  out  1  memory request valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory byte strobes; all zero for reads
- mem_ready  in  1  memory accepts/completes the request in this cycle
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ready is high
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n low, takes effect immediately):
  - state=IDLE, starve_cnt=0.
  - All outputs 0: mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ack, dm_ack, if_rdata, dm_rdata, busy.
  - A transaction in progress is abandoned and no ack is produced.
- States are IDLE, GNT_IF, GNT_DM and DRAIN_IF.
- IDLE arbitration, evaluated at a clock edge:
  - dm_req and (starve_cnt < STARVE_MAX or if_req=0 or if_flush=1) -> GNT_DM.
  - Otherwise if_req and not if_flush -> GNT_IF.
  - Otherwise stay in IDLE.
  - On the transition, register the winner's addr/we/wdata/wstrb onto the mem_* outputs and set mem_valid=1.
- Memory side:
  - mem_valid and all mem_* outputs are held stable until mem_ready is sampled high.
  - mem_valid deasserts in the cycle after that edge, and the state returns to IDLE.
  - mem_valid is never high for two back-to-back transactions without an intervening IDLE cycle.
- Minimum latency:
  - req high at edge N, mem_valid from N+1, mem_ready high at edge N+1.
  - Ack and registered rdata are high for exactly one cycle after edge N+1, so 2 cycles in total.
  - Each extra mem_ready wait cycle adds one cycle.
- Acks:
  - GNT_IF with mem_ready registers if_rdata<=mem_rdata and pulses if_ack.
  - GNT_DM with mem_ready pulses dm_ack and registers dm_rdata<=mem_rdata for loads; for stores dm_rdata is 0.
  - The ack and IDLE are reached together; the client deasserts req or presents a new one in the ack cycle. A request still high in the ack cycle is treated as a new request.
- Starvation counter:
  - starve_cnt increments, saturating at STARVE_MAX, on each GNT_DM entry while if_req=1.
  - It clears on GNT_IF entry and whenever if_req=0.
- Flush:
  - if_flush in GNT_IF (with or without mem_ready) -> DRAIN_IF. If mem_ready is high in that same cycle, the transfer completes and the state goes to IDLE with no if_ack.
  - DRAIN_IF keeps mem_valid high until mem_ready, suppresses if_ack and discards the data.
  - if_flush in IDLE blocks an IF grant in that cycle.
  - if_flush has no effect on GNT_DM.
- Simultaneous if_req and dm_req with starve_cnt=STARVE_MAX -> IF wins; starve_cnt clears.
- if_stall and dm_stall are combinational from req and the registered ack. No other output has a combinational path from any input.

Decomposition:
- Shared package pipe_mem_pkg contains:
  - the state enum (IDLE/GNT_IF/GNT_DM/DRAIN_IF)
  - the client id constants CLI_IF=0 and CLI_DM=1
  - the STARVE_MAX default
- One sub-module, mem_arb_prio: the combinational priority select plus the saturating starve_cnt register, with output grant id. The FSM and datapath registers stay in the top.

Test Plan:
- if_req=1, if_addr=0x0000_0010, mem_ready tied high, mem_rdata=0x0000_0093:
  - mem_valid at edge+1 with mem_addr=0x10.
  - if_ack pulses one cycle later with if_rdata=0x93.
  - if_stall is high for 2 cycles.
- dm_req store, dm_addr=0x100, dm_wdata=0xDEADBEEF, wstrb=4'b0011, mem_ready delayed 3 cycles:
  - mem_* outputs stable for 4 cycles.
  - dm_ack pulses once.
  - mem_wstrb=0011.
- if_req and dm_req both held continuously, STARVE_MAX=4, zero-wait memory:
  - Grant order is DM,DM,DM,DM,IF,DM…
  - The IF gap never exceeds 4 DM grants.
- GNT_IF in progress, mem_ready low, if_flush pulsed, mem_ready high 2 cycles later:
  - No if_ack.
  - busy stays high until IDLE.
  - The next if_req with a new address is granted normally.
- reset_n dropped while GNT_DM is waiting on mem_ready:
  - mem_valid, dm_ack and busy go 0 immediately, before the next clock edge.
  - After release, the state is IDLE and starve_cnt=0.
- Load of 0x1234_5678 from 0x200 followed immediately by a store:
  - dm_rdata is 0x12345678 in the load ack cycle.
  - The store starts one IDLE cycle later.
  - dm_rdata is 0 in the store ack cycle.

Source files
------------

// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
package pipe_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2,
        DRAIN_IF = 2'd3
    } state_t;

    localparam logic CLI_IF = 1'b0;
    localparam logic CLI_DM = 1'b1;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed MEM-first priority select with a saturating IF starvation counter.
module mem_arb_prio
    import pipe_mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_arb_en,
    input  logic i_if_req,
    input  logic i_if_flush,
    input  logic i_dm_req,
    output logic o_grant_vld,
    output logic o_grant_id
);

    localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;
    logic       w_dm_win;
    logic       w_if_win;

    // DM yields only when IF has waited STARVE_MAX grants and is actually eligible.
    assign w_dm_win    = i_dm_req & ((r_starve_cnt < LP_MAX) | ~i_if_req | i_if_flush);
    assign w_if_win    = ~w_dm_win & i_if_req & ~i_if_flush;
    assign o_grant_vld = w_dm_win | w_if_win;
    assign o_grant_id  = w_dm_win ? CLI_DM : CLI_IF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (!i_if_req) begin
            r_starve_cnt <= '0;
        end else if (i_arb_en && w_if_win) begin
            r_starve_cnt <= '0;
        end else if (i_arb_en && w_dm_win && (r_starve_cnt < LP_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one single-ported memory.
module pipe_mem_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ack,
    output logic                dm_stall,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant_vld;
    logic                w_grant_id;
    logic                w_arb_en;
    logic                w_start;
    logic                w_done;

    logic                r_mem_valid;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W/8-1:0] r_mem_wstrb;
    logic                r_if_ack;
    logic                r_dm_ack;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    assign w_arb_en = (r_state == IDLE);
    assign w_start  = w_arb_en & w_grant_vld;
    assign w_done   = ~w_arb_en & mem_ready;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_arb_en   (w_arb_en),
        .i_if_req   (if_req),
        .i_if_flush (if_flush),
        .i_dm_req   (dm_req),
        .o_grant_vld(w_grant_vld),
        .o_grant_id (w_grant_id)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_vld) w_state_nxt = (w_grant_id == CLI_DM) ? GNT_DM : GNT_IF;
            end
            GNT_IF: begin
                if (mem_ready)     w_state_nxt = IDLE;
                else if (if_flush) w_state_nxt = DRAIN_IF;
            end
            GNT_DM: begin
                if (mem_ready) w_state_nxt = IDLE;
            end
            DRAIN_IF: begin
                if (mem_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            if (w_start) begin
                r_mem_valid <= 1'b1;
                if (w_grant_id == CLI_DM) begin
                    r_mem_we    <= dm_we;
                    r_mem_addr  <= dm_addr;
                    r_mem_wdata <= dm_wdata;
                    r_mem_wstrb <= dm_we ? dm_wstrb : '0;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= if_addr;
                    r_mem_wdata <= '0;
                    r_mem_wstrb <= '0;
                end
            end else if (w_done) begin
                r_mem_valid <= 1'b0;
                // A flush arriving in the completing cycle still discards the fetch.
                if (r_state == GNT_IF && !if_flush) begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= mem_rdata;
                end
                if (r_state == GNT_DM) begin
                    r_dm_ack   <= 1'b1;
                    r_dm_rdata <= r_mem_we ? '0 : mem_rdata;
                end
            end
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign busy      = (r_state != IDLE);
    assign if_stall  = if_req & ~r_if_ack;
    assign dm_stall  = dm_req & ~r_dm_ack;

endmodule
